// File: rtl/dram_nport_arbiter.sv
// dram_nport_arbiter
//   N-port block-transfer DRAM model with round-robin arbitration. It serves one
//   block read or block write at a time. Each transfer spends LATENCY cycles in
//   ACCESS, then one RESP cycle that pulses the winning port's ack.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset (storage array is not reset)
//   req_i        per-port request, held until that port's ack
//   we_i         per-port 1=block write, 0=block read
//   addr_i       per-port word address, port k at [k*ADDR_W +: ADDR_W]
//   wdata_i      per-port write block, word j of port k at [(k*BLOCK_WORDS+j)*WORD_W +: WORD_W]
//   rdata_o      shared read block, holds the last completed read
//   ack_o        one-cycle completion pulse, one-hot or zero
//   grant_id_o   index of the port currently / last granted
//   busy_o       high whenever a transfer is in ACCESS or RESP
module dram_nport_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 16,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 8,
    parameter int MEM_BLOCKS  = 1024,
    localparam int ID_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int BLK_BITS   = BLOCK_WORDS * WORD_W
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]       addr_i,
    input  logic [NUM_PORTS*BLK_BITS-1:0]     wdata_i,
    output logic [BLK_BITS-1:0]               rdata_o,
    output logic [NUM_PORTS-1:0]              ack_o,
    output logic [ID_W-1:0]                   grant_id_o,
    output logic                              busy_o
);

    localparam int OFS_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 0;
    localparam int BLK_W = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [BLK_BITS-1:0] wblk_q, wblk_d;
    logic [BLK_BITS-1:0] rdata_q, rdata_d;
    logic                mem_wr;

    logic [BLK_BITS-1:0] mem_q [MEM_BLOCKS];

    // Round-robin pick: first requesting port at or after rr_q, wrapping.
    logic                found;
    logic [ID_W-1:0]     sel;
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

    // Block index: drop the word offset, then keep the low BLK_W bits so the
    // index wraps modulo MEM_BLOCKS. Zero-extension covers BLK_W > ADDR_W.
    logic [ADDR_W-1:0]       sel_addr;
    logic [ADDR_W+BLK_W-1:0] addr_ext;
    logic [BLK_W-1:0]        sel_blk;
    logic [BLK_BITS-1:0]     sel_wblk;
    always_comb begin
        sel_addr = addr_i[int'(sel)*ADDR_W +: ADDR_W];
        addr_ext = {{BLK_W{1'b0}}, sel_addr} >> OFS_W;
        sel_blk  = addr_ext[BLK_W-1:0];
        sel_wblk = wdata_i[int'(sel)*BLK_BITS +: BLK_BITS];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        blk_d   = blk_q;
        wblk_d  = wblk_q;
        rdata_d = rdata_q;
        mem_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_ACCESS;
                    grant_d = sel;
                    we_d    = we_i[sel];
                    blk_d   = sel_blk;
                    wblk_d  = sel_wblk;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    if (we_q) mem_wr  = 1'b1;
                    else      rdata_d = mem_q[blk_q];
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                rr_d    = (grant_q == ID_LAST) ? '0 : grant_q + ID_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            blk_q   <= '0;
            wblk_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            blk_q   <= blk_d;
            wblk_q  <= wblk_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is not reset. A reset mid-transfer forces IDLE asynchronously,
    // so mem_wr cannot fire for the aborted write.
    always_ff @(posedge clk_i) begin
        if (mem_wr) mem_q[blk_q] <= wblk_q;
    end

    always_comb begin
        ack_o = '0;
        if (state_q == S_RESP) ack_o[grant_q] = 1'b1;
    end

    assign rdata_o    = rdata_q;
    assign grant_id_o = grant_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dram_nport_arbiter.sv
// tb_dram_nport_arbiter
//   Bench for dram_nport_arbiter. The main instance has 4 ports and LATENCY=8.
//   A transaction-level model follows it every cycle: grant time, ack time,
//   round-robin pointer, memory contents and read data. A second instance with
//   2 ports and LATENCY=1 covers block-index wrap and the minimum latency.
//   Directed scenarios add literal expectations on top of the model.
module tb_dram_nport_arbiter;

    localparam int NP  = 4;
    localparam int LAT = 8;

    logic           clk, rst_n;
    logic [3:0]     req, we, ack;
    logic [63:0]    addr;
    logic [511:0]   wdata;
    logic [127:0]   rdata;
    logic [1:0]     gid;
    logic           busy;

    logic [1:0]     f_req, f_we, f_ack;
    logic [31:0]    f_addr;
    logic [255:0]   f_wdata;
    logic [127:0]   f_rdata;
    logic [0:0]     f_gid;
    logic           f_busy;

    int n_chk = 0;
    int n_fail = 0;

    dram_nport_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .WORD_W(32), .BLOCK_WORDS(4),
                         .LATENCY(8), .MEM_BLOCKS(1024)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .grant_id_o(gid), .busy_o(busy));

    dram_nport_arbiter #(.NUM_PORTS(2), .ADDR_W(16), .WORD_W(32), .BLOCK_WORDS(4),
                         .LATENCY(1), .MEM_BLOCKS(1024)) u_fast (
        .clk_i(clk), .rst_ni(rst_n), .req_i(f_req), .we_i(f_we), .addr_i(f_addr),
        .wdata_i(f_wdata), .rdata_o(f_rdata), .ack_o(f_ack), .grant_id_o(f_gid), .busy_o(f_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model of the main instance ----------------
    int            ecnt = 0;
    bit            m_act;
    int            m_g, m_port, m_rr, m_gid, m_blk;
    bit            m_we;
    logic [127:0]  m_wblk, m_rdata;
    bit            m_rknown;
    logic [127:0]  m_mem [int];

    function automatic void model_reset();
        m_act    = 1'b0;
        m_rr     = 0;
        m_gid    = 0;
        m_port   = 0;
        m_rdata  = '0;
        m_rknown = 1'b1;
    endfunction

    initial model_reset();
    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        ecnt++;
        if (!rst_n) begin
            model_reset();
        end else if (m_act) begin
            if (ecnt - m_g == LAT) begin
                if (m_we) m_mem[m_blk] = m_wblk;
                else if (m_mem.exists(m_blk)) begin
                    m_rdata  = m_mem[m_blk];
                    m_rknown = 1'b1;
                end else m_rknown = 1'b0;
            end else if (ecnt - m_g == LAT + 1) begin
                m_act = 1'b0;
                m_rr  = (m_port + 1) % NP;
            end
        end else if (req != 4'd0) begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < NP; i++) begin
                int p;
                p = (m_rr + i) % NP;
                if (!got && req[p]) begin
                    got    = 1'b1;
                    m_port = p;
                end
            end
            m_act  = 1'b1;
            m_g    = ecnt;
            m_gid  = m_port;
            m_we   = we[m_port];
            m_blk  = (int'(addr[m_port*16 +: 16]) >> 2) % 1024;
            m_wblk = wdata[m_port*128 +: 128];
        end
    end

    logic [3:0] e_ack;
    always @(negedge clk) begin
        if (rst_n) begin
            e_ack = (m_act && (ecnt - m_g == LAT)) ? 4'(1 << m_port) : 4'd0;
            chk("ack", ack, e_ack);
            chk("busy", busy, m_act);
            chk("grant_id", gid, m_gid[1:0]);
            if (m_rknown) chk("rdata", rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer on the main instance. With mangle set, the port's
    // addr/wdata are altered right after the grant edge.
    task automatic xfer(input int p, input bit w, input logic [15:0] a, input logic [127:0] d,
                        input bit mangle, output logic [127:0] rd, output int ticks);
        we[p] = w;
        addr[p*16 +: 16] = a;
        wdata[p*128 +: 128] = d;
        req[p] = 1'b1;
        ticks = 0;
        do begin
            tick();
            ticks++;
            if (mangle && ticks == 1) begin
                addr[p*16 +: 16] = a ^ 16'h0040;
                wdata[p*128 +: 128] = ~d;
            end
        end while (!ack[p] && ticks < 40);
        chk("xfer_ack_seen", {127'd0, ack[p]}, 128'd1);
        rd = rdata;
        req[p] = 1'b0;
        tick();
    endtask

    localparam logic [127:0] D1 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] DA = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
    localparam logic [127:0] DC = 128'hCCCC0001_CCCC0002_CCCC0003_CCCC0004;
    localparam logic [127:0] DO = 128'h0DD00001_0DD00002_0DD00003_0DD00004;
    localparam logic [127:0] DN = 128'h5EE00001_5EE00002_5EE00003_5EE00004;
    localparam logic [127:0] DE = 128'hEEEE0001_EEEE0002_EEEE0003_EEEE0004;

    initial begin
        logic [127:0] rd;
        int t, idx, nseen;
        int order [5];
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        f_req = '0; f_we = '0; f_addr = '0; f_wdata = '0;
        repeat (3) tick();
        chk("reset_ack", ack, 0);
        chk("reset_busy", busy, 0);
        chk("reset_gid", gid, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_fast_rdata", f_rdata, 0);
        rst_n = 1'b1;
        tick();

        // Write/read through the same block with different word offsets.
        xfer(1, 1'b1, 16'h0040, D1, 1'b0, rd, t);
        chk("t2_write_latency", t, 9);
        xfer(0, 1'b0, 16'h0043, '0, 1'b0, rd, t);
        chk("t2_read_latency", t, 9);
        chk("t2_read_data", rd, 128'h00000004_00000003_00000002_00000001);

        // Latching at grant: later addr/wdata changes must not leak in.
        xfer(1, 1'b1, 16'h00C0, DC, 1'b0, rd, t);
        xfer(1, 1'b1, 16'h0080, DA, 1'b1, rd, t);
        xfer(0, 1'b0, 16'h0080, '0, 1'b0, rd, t);
        chk("t6_latched_data", rd, DA);
        xfer(0, 1'b0, 16'h00C0, '0, 1'b0, rd, t);
        chk("t6_other_block_untouched", rd, DC);

        // Reset in the middle of a write: no commit, outputs clear immediately.
        xfer(2, 1'b1, 16'h0100, DO, 1'b0, rd, t);
        we[2] = 1'b1; addr[32 +: 16] = 16'h0100; wdata[256 +: 128] = DN; req[2] = 1'b1;
        repeat (4) tick();
        chk("t1_busy_before", busy, 1);
        chk("t1_gid_before", gid, 2);
        rst_n = 1'b0;
        #1;
        chk("t1_ack_in_reset", ack, 0);
        chk("t1_busy_in_reset", busy, 0);
        chk("t1_gid_in_reset", gid, 0);
        req[2] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        xfer(0, 1'b0, 16'h0100, '0, 1'b0, rd, t);
        chk("t1_old_contents", rd, DO);

        // Round-robin with all four ports requesting from reset.
        rst_n = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            addr[k*16 +: 16] = 16'h0200 + 16'(k * 16);
            wdata[k*128 +: 128] = {96'd0, 32'(k + 100)};
        end
        we = 4'hF;
        req = 4'hF;
        tick();
        rst_n = 1'b1;
        nseen = 0;
        for (int c = 0; c < 80 && nseen < 5; c++) begin
            tick();
            if (ack != 4'd0) begin
                chk("t3_onehot", {127'd0, $onehot(ack)}, 128'd1);
                idx = 0;
                for (int k = 0; k < 4; k++) if (ack[k]) idx = k;
                order[nseen] = idx;
                nseen++;
            end
        end
        chk("t3_ack_count", nseen, 5);
        req = '0;
        for (int k = 0; k < 5; k++) chk("t3_order", order[k], exp_order[k]);
        tick();
        tick();

        // Fairness: port0 holds req continuously, port2 must win the second grant.
        xfer(3, 1'b1, 16'h0300, DE, 1'b0, rd, t);
        we[0] = 1'b1; addr[0 +: 16] = 16'h0400; wdata[0 +: 128] = DC;
        we[2] = 1'b1; addr[32 +: 16] = 16'h0410; wdata[256 +: 128] = DA;
        req[0] = 1'b1; req[2] = 1'b1;
        nseen = 0;
        for (int c = 0; c < 60 && nseen < 2; c++) begin
            tick();
            if (ack != 4'd0) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (ack[k]) idx = k;
                order[nseen] = idx;
                nseen++;
            end
        end
        chk("t4_ack_count", nseen, 2);
        req = '0;
        chk("t4_first_grant", order[0], 0);
        chk("t4_second_grant", order[1], 2);
        tick();
        tick();

        // Block-index wrap and minimum latency on the fast instance.
        f_we[1] = 1'b1; f_addr[31:16] = 16'h1000; f_wdata[255:128] = DE; f_req[1] = 1'b1;
        t = 0;
        do begin tick(); t++; end while (!f_ack[1] && t < 20);
        chk("t5_write_latency", t, 2);
        f_req[1] = 1'b0;
        tick();
        f_we[0] = 1'b0; f_addr[15:0] = 16'h0002; f_req[0] = 1'b1;
        t = 0;
        do begin tick(); t++; end while (!f_ack[0] && t < 20);
        chk("t5_read_latency", t, 2);
        chk("t5_wrap_data", f_rdata, DE);
        chk("t5_fast_gid", f_gid, 0);
        f_req[0] = 1'b0;
        tick();
        chk("t5_fast_idle", f_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
